// File: rtl/rot_sq_pkg.sv
// Shared constants and decode helpers for the clockwise square rotator.
// Segment vectors are {dp,g,f,e,d,c,b,a}, active low.
package rot_sq_pkg;

    localparam logic [7:0] TOP    = 8'b1001_1100;
    localparam logic [7:0] BOTTOM = 8'b1010_0011;
    localparam int         NPOS   = 8;

    // Top row walks left to right, bottom row walks back right to left.
    function automatic logic [3:0] pos_to_an(input logic [2:0] pos);
        logic [1:0] idx;
        idx = pos[2] ? (2'd3 - pos[1:0]) : pos[1:0];
        return ~(4'b1000 >> idx);
    endfunction

    function automatic logic [7:0] pos_to_sseg(input logic [2:0] pos);
        return pos[2] ? BOTTOM : TOP;
    endfunction

endpackage

// File: rtl/rot_tick_gen.sv
// Step-rate prescaler; speed shifts the terminal count down.
// The >= compare makes a mid-count speed increase fire immediately.
module rot_tick_gen #(
    parameter int DIV_W = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] speed,
    output logic       tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] limit;

    assign limit = {DIV_W{1'b1}} >> speed;
    assign tick  = en && (cnt >= limit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rotating_square_cw.sv
// Clockwise square glyph rotator for the 4-digit seven-segment display.
// Free-runs from the prescaler or single-steps from step_btn while paused.
module rotating_square_cw
    import rot_sq_pkg::*;
#(
    parameter int DIV_W       = 26,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] speed,
    input  logic       step_btn,
    output logic [3:0] an,
    output logic [7:0] sseg,
    output logic [2:0] pos,
    output logic       step_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   tick;
    logic                   step_req;
    logic                   adv;
    logic [2:0]             pos_q;
    logic [2:0]             pos_n;

    rot_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .speed (speed),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], step_btn};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Edges seen while running are dropped, not queued.
    assign step_req = sync_q[SYNC_STAGES-1] & ~prev_q & ~en;
    assign adv      = tick | step_req;
    assign pos_n    = adv ? pos_q + 3'd1 : pos_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q      <= '0;
            an         <= pos_to_an(3'd0);
            sseg       <= TOP;
            step_pulse <= 1'b0;
        end else begin
            pos_q      <= pos_n;
            an         <= pos_to_an(pos_n);
            sseg       <= pos_to_sseg(pos_n);
            step_pulse <= adv;
        end
    end

    assign pos = pos_q;

endmodule

// File: tb/tb_rotating_square_cw.sv
// Directed bench for rotating_square_cw with DIV_W=4, SYNC_STAGES=2.
module tb_rotating_square_cw;

    localparam logic [7:0] T_E = 8'h9C;
    localparam logic [7:0] B_E = 8'hA3;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] speed;
    logic       step_btn;
    logic [3:0] an;
    logic [7:0] sseg;
    logic [2:0] pos;
    logic       step_pulse;

    int n_chk;
    int n_fail;

    typedef struct {
        logic       en;
        logic [1:0] speed;
        int         cycles;
        logic [2:0] pos;
        logic [3:0] an;
        logic [7:0] sseg;
        logic       pulse;
    } vec_t;

    vec_t vecs[14];

    rotating_square_cw #(
        .DIV_W       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .speed      (speed),
        .step_btn   (step_btn),
        .an         (an),
        .sseg       (sseg),
        .pos        (pos),
        .step_pulse (step_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] p,
                           input logic [3:0] a, input logic [7:0] s,
                           input logic sp);
        chk({tag, ".pos"}, {5'd0, pos}, {5'd0, p});
        chk({tag, ".an"}, {4'd0, an}, {4'd0, a});
        chk({tag, ".sseg"}, sseg, s);
        chk({tag, ".pulse"}, {7'd0, step_pulse}, {7'd0, sp});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Assert reset over one rising edge, release on a falling edge.
    task automatic do_reset(input logic e, input logic [1:0] s);
        reset = 1'b1;
        en    = e;
        speed = s;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        reset    = 1'b1;
        en       = 1'b1;
        speed    = 2'd3;
        step_btn = 1'b0;

        vecs[0]  = '{1'b1, 2'd3, 1, 3'd0, 4'b0111, T_E, 1'b0};
        vecs[1]  = '{1'b1, 2'd3, 1, 3'd1, 4'b1011, T_E, 1'b1};
        vecs[2]  = '{1'b1, 2'd3, 2, 3'd2, 4'b1101, T_E, 1'b1};
        vecs[3]  = '{1'b1, 2'd3, 2, 3'd3, 4'b1110, T_E, 1'b1};
        vecs[4]  = '{1'b1, 2'd3, 2, 3'd4, 4'b1110, B_E, 1'b1};
        vecs[5]  = '{1'b1, 2'd3, 2, 3'd5, 4'b1101, B_E, 1'b1};
        vecs[6]  = '{1'b1, 2'd3, 2, 3'd6, 4'b1011, B_E, 1'b1};
        vecs[7]  = '{1'b1, 2'd3, 2, 3'd7, 4'b0111, B_E, 1'b1};
        vecs[8]  = '{1'b1, 2'd3, 2, 3'd0, 4'b0111, T_E, 1'b1};
        vecs[9]  = '{1'b1, 2'd3, 1, 3'd0, 4'b0111, T_E, 1'b0};
        vecs[10] = '{1'b0, 2'd3, 20, 3'd0, 4'b0111, T_E, 1'b0};
        vecs[11] = '{1'b1, 2'd3, 1, 3'd1, 4'b1011, T_E, 1'b1};
        vecs[12] = '{1'b1, 2'd2, 1, 3'd1, 4'b1011, T_E, 1'b0};
        vecs[13] = '{1'b1, 2'd2, 3, 3'd2, 4'b1101, T_E, 1'b1};

        // Reset state while reset is still held.
        @(negedge clk);
        chk_all("rst", 3'd0, 4'b0111, T_E, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            en    = vecs[i].en;
            speed = vecs[i].speed;
            cyc(vecs[i].cycles);
            chk_all($sformatf("vec%0d", i), vecs[i].pos, vecs[i].an,
                    vecs[i].sseg, vecs[i].pulse);
        end

        // Speed raised mid-count fires on the next edge.
        do_reset(1'b1, 2'd0);
        cyc(10);
        chk("spd.pre", {5'd0, pos}, 8'd0);
        speed = 2'd3;
        cyc(1);
        chk_all("spd.fire", 3'd1, 4'b1011, T_E, 1'b1);
        cyc(1);
        chk_all("spd.gap", 3'd1, 4'b1011, T_E, 1'b0);
        cyc(1);
        chk_all("spd.next", 3'd2, 4'b1101, T_E, 1'b1);

        // Pause at pos 5 with cnt=6, resume after the remaining count.
        do_reset(1'b1, 2'd0);
        cyc(80);
        chk("pause.at5", {5'd0, pos}, 8'd5);
        cyc(6);
        en = 1'b0;
        cyc(50);
        chk_all("pause.hold", 3'd5, 4'b1101, B_E, 1'b0);
        en = 1'b1;
        cyc(9);
        chk("pause.rem9", {5'd0, pos}, 8'd5);
        cyc(1);
        chk_all("pause.rem10", 3'd6, 4'b1011, B_E, 1'b1);

        // Single steps while paused; holding gives one step only.
        do_reset(1'b0, 2'd3);
        for (int k = 0; k < 3; k++) begin
            step_btn = 1'b1;
            cyc(2);
            chk($sformatf("step%0d.lat2", k), {5'd0, pos}, k[7:0]);
            cyc(1);
            chk($sformatf("step%0d.lat3", k), {5'd0, pos}, k[7:0] + 8'd1);
            chk($sformatf("step%0d.pulse", k), {7'd0, step_pulse}, 8'd1);
            cyc(7);
            chk($sformatf("step%0d.held", k), {5'd0, pos}, k[7:0] + 8'd1);
            step_btn = 1'b0;
            cyc(10);
        end
        chk_all("step.final", 3'd3, 4'b1110, T_E, 1'b0);

        // Button toggling while running adds no steps; 7 -> 0 wrap.
        do_reset(1'b1, 2'd3);
        for (int k = 0; k < 14; k++) begin
            step_btn = ~step_btn;
            cyc(1);
        end
        chk_all("run.pos7", 3'd7, 4'b0111, B_E, 1'b1);
        for (int k = 0; k < 2; k++) begin
            step_btn = ~step_btn;
            cyc(1);
        end
        chk_all("run.wrap", 3'd0, 4'b0111, T_E, 1'b1);
        step_btn = 1'b0;

        // Asynchronous reset between edges.
        do_reset(1'b1, 2'd3);
        cyc(12);
        chk_all("arst.pre", 3'd6, 4'b1011, B_E, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_all("arst.now", 3'd0, 4'b0111, T_E, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        cyc(2);
        chk("arst.first", {5'd0, pos}, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
